// File: rtl/fir_mc_decim_engine.sv
// ---------------------------------------------------------------------------
// fir_mc_decim_engine
// Time-multiplexed multichannel FIR with per-channel decimation, optional
// symmetric folding, rounding/saturation and a serial coefficient-load port.
// One multiply per cycle through a registered multiplier; one sample is in
// flight at a time.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   Config_Start       pulse: begin loading NTAPS coefficient words
//   Config_Valid/Data  coefficient word strobe and value, index 0 first
//   Config_Busy        high while the load is in progress
//   Config_Done        one-cycle pulse after the last coefficient word
//   Sym_En             symmetric folding for the accepted sample
//   Decim_Factor       per-sample decimation factor (0 behaves as 1)
//   Data_In*           sample, channel index, valid; Data_In_Ready handshake
//   Data_Out*          filtered sample, channel, strobe and clip flag
// ---------------------------------------------------------------------------
module fir_mc_decim_engine #(
   parameter int DATA_W    = 24,
   parameter int COEF_W    = 24,
   parameter int OUT_W     = 24,
   parameter int ACC_W     = 64,
   parameter int NTAPS     = 64,
   parameter int NUM_CH    = 4,
   parameter int OUT_SHIFT = 23
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              Config_Start,
   input  logic              Config_Valid,
   input  logic [COEF_W-1:0] Config_Data,
   output logic              Config_Busy,
   output logic              Config_Done,
   input  logic              Sym_En,
   input  logic [3:0]        Decim_Factor,
   input  logic [DATA_W-1:0] Data_In,
   input  logic [3:0]        Data_In_ChIdx,
   input  logic              Data_In_Valid,
   output logic              Data_In_Ready,
   output logic [OUT_W-1:0]  Data_Out,
   output logic [3:0]        Data_Out_ChIdx,
   output logic              Data_Out_Valid,
   output logic              Data_Out_Sat
);

   localparam int PTR_W  = $clog2(NTAPS);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int HALF   = (NTAPS + 1) / 2;
   localparam int PROD_W = COEF_W + DATA_W + 1;
   localparam bit ODD_TAPS = (NTAPS % 2) == 1;
   localparam logic [PTR_W-1:0] LAST_TAP  = PTR_W'(NTAPS - 1);
   localparam logic [PTR_W-1:0] LAST_HALF = PTR_W'(HALF - 1);
   localparam logic [PTR_W-1:0] CENTRE    = PTR_W'((NTAPS - 1) / 2);
   localparam logic [ACC_W-1:0] ONE       = ACC_W'(1);
   // Half an output LSB; collapses to zero when OUT_SHIFT is 0.
   localparam logic signed [ACC_W-1:0] RND     = (ONE << OUT_SHIFT) >> 1;
   localparam logic signed [ACC_W-1:0] OUT_MAX = (ONE << (OUT_W - 1)) - ONE;
   localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_FLUSH, S_OUT, S_LOAD} state_t;

   state_t                   state_q, state_d;
   logic signed [COEF_W-1:0] coef_q [NTAPS];
   logic signed [DATA_W-1:0] hist_q [NUM_CH][NTAPS];
   logic [PTR_W-1:0]         wp_q   [NUM_CH];
   logic [3:0]               phase_q[NUM_CH];

   logic             skip_q, skip_d, cfg_pend_q, cfg_pend_d;
   logic             sym_q, sym_d, flush_q, flush_d;
   logic [3:0]       ch_q, ch_d;
   logic [PTR_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d, term_q, term_d;
   logic [PTR_W-1:0] cfg_idx_q, cfg_idx_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic [3:0]       och_q, och_d;
   logic             ovld_q, ovld_d, osat_q, osat_d, done_q, done_d;

   logic signed [PROD_W-1:0] prod_q;
   logic                     prod_vld_q;
   logic signed [ACC_W-1:0]  acc_q;

   logic                     accept, ch_ok, do_compute;
   logic                     hist_we, coef_we, mul_en, acc_clr;
   logic [CH_W-1:0]          in_ch;
   logic [3:0]               dec_eff;
   logic [PTR_W-1:0]         wp_next;
   logic signed [DATA_W-1:0] tap_a, tap_b;
   logic signed [DATA_W:0]   pre_add;
   logic signed [ACC_W-1:0]  rounded, shifted;

   assign Data_In_Ready  = (state_q == S_IDLE) && !skip_q;
   assign Config_Busy    = (state_q == S_LOAD);
   assign Config_Done    = done_q;
   assign Data_Out       = dout_q;
   assign Data_Out_ChIdx = och_q;
   assign Data_Out_Valid = ovld_q;
   assign Data_Out_Sat   = osat_q;

   assign accept  = Data_In_Valid && Data_In_Ready;
   assign ch_ok   = {1'b0, Data_In_ChIdx} < 5'(NUM_CH);
   assign in_ch   = Data_In_ChIdx[CH_W-1:0];
   assign dec_eff = (Decim_Factor == 4'd0) ? 4'd1 : Decim_Factor;
   // ">=" rather than "==" so a factor lowered mid-stream still wraps.
   assign do_compute = ch_ok && (phase_q[in_ch] >= dec_eff - 4'd1);
   assign wp_next = (wp_q[in_ch] == LAST_TAP) ? '0 : wp_q[in_ch] + 1'b1;

   // rd0 walks backwards from the newest sample, rd1 forwards from the oldest,
   // so the pair always addresses the two taps folded onto coefficient term_q.
   assign tap_a = hist_q[ch_q[CH_W-1:0]][rd0_q];
   assign tap_b = hist_q[ch_q[CH_W-1:0]][rd1_q];

   assign rounded = acc_q + RND;
   assign shifted = rounded >>> OUT_SHIFT;

   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      pre_add = {tap_a[DATA_W-1], tap_a};
      if (sym_q && !(ODD_TAPS && (term_q == CENTRE)))
         pre_add = {tap_a[DATA_W-1], tap_a} + {tap_b[DATA_W-1], tap_b};
   end

   always_comb begin
      state_d    = state_q;
      skip_d     = 1'b0;
      cfg_pend_d = cfg_pend_q || Config_Start;
      sym_d      = sym_q;
      flush_d    = flush_q;
      ch_d       = ch_q;
      rd0_d      = rd0_q;
      rd1_d      = rd1_q;
      term_d     = term_q;
      cfg_idx_d  = cfg_idx_q;
      dout_d     = dout_q;
      och_d      = och_q;
      ovld_d     = 1'b0;
      osat_d     = osat_q;
      done_d     = 1'b0;
      hist_we    = 1'b0;
      coef_we    = 1'b0;
      mul_en     = 1'b0;
      acc_clr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               // A sample beats a simultaneous Config_Start; the start stays pending.
               hist_we = ch_ok;
               if (do_compute) begin
                  state_d = S_MAC;
                  ch_d    = Data_In_ChIdx;
                  sym_d   = Sym_En;
                  rd0_d   = wp_next;
                  rd1_d   = (wp_next == LAST_TAP) ? '0 : wp_next + 1'b1;
                  term_d  = '0;
                  acc_clr = 1'b1;
               end else begin
                  skip_d = 1'b1;
               end
            end else if (cfg_pend_q || Config_Start) begin
               state_d    = S_LOAD;
               cfg_idx_d  = '0;
               cfg_pend_d = 1'b0;
            end
         end
         S_MAC: begin
            mul_en = 1'b1;
            rd0_d  = (rd0_q == '0) ? LAST_TAP : rd0_q - 1'b1;
            rd1_d  = (rd1_q == LAST_TAP) ? '0 : rd1_q + 1'b1;
            term_d = term_q + 1'b1;
            if (term_q == (sym_q ? LAST_HALF : LAST_TAP)) begin
               state_d = S_FLUSH;
               flush_d = 1'b0;
            end
         end
         S_FLUSH: begin
            // Two cycles: one for the last product, one for its accumulate.
            flush_d = 1'b1;
            if (flush_q) state_d = S_OUT;
         end
         S_OUT: begin
            state_d = S_IDLE;
            ovld_d  = 1'b1;
            och_d   = ch_q;
            osat_d  = (shifted > OUT_MAX) || (shifted < OUT_MIN);
            if (shifted > OUT_MAX)      dout_d = OUT_MAX[OUT_W-1:0];
            else if (shifted < OUT_MIN) dout_d = OUT_MIN[OUT_W-1:0];
            else                        dout_d = shifted[OUT_W-1:0];
         end
         S_LOAD: begin
            cfg_pend_d = 1'b0;
            if (Config_Start) begin
               cfg_idx_d = '0;
            end else if (Config_Valid) begin
               coef_we   = 1'b1;
               cfg_idx_d = cfg_idx_q + 1'b1;
               if (cfg_idx_q == LAST_TAP) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= S_IDLE;
         skip_q     <= 1'b0;
         cfg_pend_q <= 1'b0;
         sym_q      <= 1'b0;
         flush_q    <= 1'b0;
         ch_q       <= '0;
         rd0_q      <= '0;
         rd1_q      <= '0;
         term_q     <= '0;
         cfg_idx_q  <= '0;
         dout_q     <= '0;
         och_q      <= '0;
         ovld_q     <= 1'b0;
         osat_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         skip_q     <= skip_d;
         cfg_pend_q <= cfg_pend_d;
         sym_q      <= sym_d;
         flush_q    <= flush_d;
         ch_q       <= ch_d;
         rd0_q      <= rd0_d;
         rd1_q      <= rd1_d;
         term_q     <= term_d;
         cfg_idx_q  <= cfg_idx_d;
         dout_q     <= dout_d;
         och_q      <= och_d;
         ovld_q     <= ovld_d;
         osat_q     <= osat_d;
         done_q     <= done_d;
      end
   end

   // NOTE: coefficient and history storage is cleared by reset so that a
   // filter coming out of reset produces silence, which keeps it in flops.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wp_q[c]    <= '0;
            phase_q[c] <= '0;
            for (int t = 0; t < NTAPS; t++) hist_q[c][t] <= '0;
         end
         for (int t = 0; t < NTAPS; t++) coef_q[t] <= '0;
      end else begin
         if (hist_we) begin
            hist_q[in_ch][wp_next] <= Data_In;
            wp_q[in_ch]            <= wp_next;
            phase_q[in_ch]         <= do_compute ? 4'd0 : phase_q[in_ch] + 4'd1;
         end
         if (coef_we) coef_q[cfg_idx_q] <= Config_Data;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         prod_vld_q <= mul_en;
         if (mul_en) prod_q <= coef_q[term_q] * pre_add;
         if (acc_clr)         acc_q <= '0;
         else if (prod_vld_q) acc_q <= acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
      end
   end

endmodule

// File: tb/tb_fir_mc_decim_engine.sv
// ---------------------------------------------------------------------------
// tb_fir_mc_decim_engine
// Directed scenarios followed by randomized traffic, all compared against a
// reference model that keeps each channel's last NTAPS samples newest-first
// and evaluates the filter as a plain dot product with mirrored coefficients.
// ---------------------------------------------------------------------------
module tb_fir_mc_decim_engine;

   localparam int DW = 24, CW = 24, OW = 24, AW = 64;
   localparam int NT = 8, NC = 4, SH = 3;
   localparam longint MAXO = (longint'(1) << (OW - 1)) - 1;
   localparam longint MINO = -(longint'(1) << (OW - 1));

   logic          CLK = 1'b0, nRST = 1'b0;
   logic          Config_Start = 1'b0, Config_Valid = 1'b0;
   logic [CW-1:0] Config_Data = '0;
   logic          Config_Busy, Config_Done;
   logic          Sym_En = 1'b0;
   logic [3:0]    Decim_Factor = 4'd1;
   logic [DW-1:0] Data_In = '0;
   logic [3:0]    Data_In_ChIdx = '0;
   logic          Data_In_Valid = 1'b0, Data_In_Ready;
   logic [OW-1:0] Data_Out;
   logic [3:0]    Data_Out_ChIdx;
   logic          Data_Out_Valid, Data_Out_Sat;

   fir_mc_decim_engine #(
      .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .ACC_W(AW),
      .NTAPS(NT), .NUM_CH(NC), .OUT_SHIFT(SH)
   ) dut (
      .CLK(CLK), .nRST(nRST),
      .Config_Start(Config_Start), .Config_Valid(Config_Valid),
      .Config_Data(Config_Data), .Config_Busy(Config_Busy), .Config_Done(Config_Done),
      .Sym_En(Sym_En), .Decim_Factor(Decim_Factor),
      .Data_In(Data_In), .Data_In_ChIdx(Data_In_ChIdx),
      .Data_In_Valid(Data_In_Valid), .Data_In_Ready(Data_In_Ready),
      .Data_Out(Data_Out), .Data_Out_ChIdx(Data_Out_ChIdx),
      .Data_Out_Valid(Data_Out_Valid), .Data_Out_Sat(Data_Out_Sat)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0, n_errors = 0;
   int n_out = 0, exp_out = 0;

   // Reference state
   longint m_coef [NT];
   longint m_hist [NC][NT];
   int     m_phase[NC];

   always @(negedge CLK) if (Data_Out_Valid === 1'b1) n_out++;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int t = 0; t < NT; t++) m_coef[t] = 0;
      for (int c = 0; c < NC; c++) begin
         m_phase[c] = 0;
         for (int t = 0; t < NT; t++) m_hist[c][t] = 0;
      end
   endfunction

   // Symmetric mode equals an ordinary FIR whose upper half mirrors the lower half.
   function automatic void model_eval(input int ch, input bit sym,
                                      output longint v, output bit s);
      longint acc = 0;
      longint r, cj;
      int m = sym ? (NT + 1) / 2 : NT;
      for (int j = 0; j < NT; j++) begin
         cj = (j < m) ? m_coef[j] : m_coef[NT - 1 - j];
         acc += cj * m_hist[ch][j];
      end
      r = (acc + ((longint'(1) << SH) >> 1)) >>> SH;
      s = 1'b1;
      if (r > MAXO)      v = MAXO;
      else if (r < MINO) v = MINO;
      else begin v = r; s = 1'b0; end
   endfunction

   // Offer one sample, then follow it cycle by cycle. cfg_at pulses Config_Start
   // at that cycle offset; rst_at abandons the transaction at that offset.
   task automatic send(input int ch, input longint x, input bit sym, input int dec,
                       input int cfg_at, input int rst_at);
      int n = 0;
      int dec_eff, m, last;
      bit comp = 1'b0, exp_sat;
      longint exp_v;
      while (!Data_In_Ready && n < 300) begin @(negedge CLK); n++; end
      check("rdy_wait", Data_In_Ready, 1);
      Data_In       = x[DW-1:0];
      Data_In_ChIdx = 4'(ch);
      Sym_En        = sym;
      Decim_Factor  = 4'(dec);
      Data_In_Valid = 1'b1;
      @(posedge CLK);
      if (ch < NC) begin
         for (int j = NT - 1; j > 0; j--) m_hist[ch][j] = m_hist[ch][j-1];
         m_hist[ch][0] = x;
         dec_eff = (dec == 0) ? 1 : dec;
         if (m_phase[ch] >= dec_eff - 1) begin comp = 1'b1; m_phase[ch] = 0; end
         else m_phase[ch]++;
      end
      if (comp) model_eval(ch, sym, exp_v, exp_sat);
      m    = sym ? (NT + 1) / 2 : NT;
      last = comp ? m + 3 : 1;
      for (int j = 0; j <= last; j++) begin
         @(negedge CLK);
         if (j == 0) Data_In_Valid = 1'b0;
         if (j == rst_at) return;
         Config_Start = (j == cfg_at);
         if (j == 0) check("rdy_drop", Data_In_Ready, 0);
         if (!comp && j == 1) begin
            check("rdy_back", Data_In_Ready, 1);
            check("no_out", Data_Out_Valid, 0);
         end
         if (comp && j == last - 1) check("out_early", Data_Out_Valid, 0);
         if (comp && j == last) begin
            exp_out++;
            check("out_valid", Data_Out_Valid, 1);
            check("out_data", longint'($signed(Data_Out)), exp_v);
            check("out_ch", Data_Out_ChIdx, ch);
            check("out_sat", Data_Out_Sat, exp_sat);
            check("rdy_at_out", Data_In_Ready, 1);
         end
      end
   endtask

   task automatic feed(input longint c [NT], input bit gaps);
      for (int i = 0; i < NT; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
         if (i == 0) begin
            check("busy_load", Config_Busy, 1);
            check("rdy_load", Data_In_Ready, 0);
         end
         Config_Valid = 1'b1;
         Config_Data  = CW'(c[i]);
         @(negedge CLK);
         Config_Valid = 1'b0;
      end
      check("cfg_done", Config_Done, 1);
      check("busy_clr", Config_Busy, 0);
      for (int i = 0; i < NT; i++) m_coef[i] = longint'($signed(CW'(c[i])));
      @(negedge CLK);
      check("done_pulse", Config_Done, 0);
   endtask

   task automatic load(input longint c [NT], input bit gaps);
      int n = 0;
      Config_Start = 1'b1;
      @(negedge CLK);
      Config_Start = 1'b0;
      while (!Config_Busy && n < 300) begin @(negedge CLK); n++; end
      check("load_start", Config_Busy, 1);
      feed(c, gaps);
   endtask

   function automatic longint rnd_sample(input bit full);
      logic signed [DW-1:0] t;
      t = DW'($urandom);
      return full ? longint'(t) : longint'($urandom_range(0, 8191)) - 4096;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint c [NT];
      int n0;
      model_reset();

      // Reset state
      #1;
      check("rst_ready", Data_In_Ready, 1);
      check("rst_valid", Data_Out_Valid, 0);
      check("rst_data", Data_Out, 0);
      check("rst_busy", Config_Busy, 0);
      check("rst_done", Config_Done, 0);
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);

      // Impulse, normal mode
      for (int i = 0; i < NT; i++) c[i] = 8 * (i + 1);
      load(c, 1'b0);
      send(0, 1, 1'b0, 1, -1, -1);
      for (int i = 0; i < NT; i++) send(0, 0, 1'b0, 1, -1, -1);

      // Impulse, symmetric mode; upper words must be ignored
      for (int i = 0; i < NT; i++) c[i] = (i < NT / 2) ? 8 * (i + 1) : 1000 + i;
      load(c, 1'b1);
      send(0, 1, 1'b1, 1, -1, -1);
      for (int i = 0; i < NT; i++) send(0, 0, 1'b1, 1, -1, -1);

      // Decimation by 3 on channel 1
      for (int i = 0; i < NT; i++) c[i] = (i == 0) ? 8 : 0;
      load(c, 1'b0);
      n0 = n_out;
      for (int i = 1; i <= 9; i++) send(1, i, 1'b0, 3, -1, -1);
      #1 check("decim_count", n_out - n0, 3);

      // Saturation, channel isolation, dropped channel index
      for (int i = 0; i < NT; i++) c[i] = (i == 0) ? (longint'(1) << 22) : 0;
      load(c, 1'b0);
      send(0, 8388607, 1'b0, 1, -1, -1);
      send(2, 0, 1'b0, 1, -1, -1);
      send(15, 123, 1'b0, 1, -1, -1);
      send(0, -8388608, 1'b0, 1, -1, -1);
      send(2, 5, 1'b0, 1, -1, -1);

      // Config_Start during MAC: output still emitted, load starts afterwards
      send(0, 3, 1'b0, 1, 2, -1);
      check("cfg_wait", Config_Busy, 0);
      @(negedge CLK);
      for (int i = 0; i < NT; i++) c[i] = 8 * (NT - i);
      feed(c, 1'b0);
      send(3, 77, 1'b0, 1, -1, -1);

      // Reset during MAC
      send(0, 100, 1'b0, 1, -1, 3);
      nRST = 1'b0;
      #1;
      check("mid_rst_valid", Data_Out_Valid, 0);
      check("mid_rst_data", Data_Out, 0);
      check("mid_rst_ch", Data_Out_ChIdx, 0);
      check("mid_rst_sat", Data_Out_Sat, 0);
      check("mid_rst_ready", Data_In_Ready, 1);
      check("mid_rst_busy", Config_Busy, 0);
      @(negedge CLK);
      nRST = 1'b1;
      model_reset();
      repeat (15) @(negedge CLK);
      #1 check("no_out_after_rst", n_out, exp_out);
      send(0, 1, 1'b0, 1, -1, -1);
      for (int i = 0; i < 3; i++) send(0, 0, 1'b0, 1, -1, -1);

      // Randomized traffic
      for (int i = 0; i < NT; i++) c[i] = longint'($urandom_range(0, 65535)) - 32768;
      load(c, 1'b1);
      for (int i = 0; i < 90; i++) begin
         int ch;
         ch = $urandom_range(0, 4);
         if (ch == 4) ch = $urandom_range(4, 15);
         send(ch, rnd_sample($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), -1, -1);
         if (i == 45) begin
            for (int k = 0; k < NT; k++) c[k] = rnd_sample(1'b1);
            load(c, 1'b1);
         end
      end

      repeat (5) @(negedge CLK);
      #1 check("out_count", n_out, exp_out);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
